sram_controller: RTL and testbench

- Sits directly downstream of the pipeline's memory stage.
- Takes a 32-bit word read/write request and performs it on an external 16-bit asynchronous SRAM as two half-word accesses.
- Deasserts `ready` while an access is in flight. The top level turns `!ready` into the pipeline `freeze` for all stages.

---
 rtl/sram_controller_pkg.sv | 25 ++
 rtl/sram_wait_counter.sv | 28 ++
 rtl/sram_controller.sv | 171 +++++++++++++++++
 tb/tb_sram_controller.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_controller_pkg.sv
// Shared widths, state encoding and address helper for the
// word-to-halfword asynchronous SRAM controller.
package sram_controller_pkg;

    localparam int ADDRESS_LEN   = 32;
    localparam int REGISTER_LEN  = 32;
    localparam int DATA_LEN      = REGISTER_LEN;
    localparam int SRAM_DATA_LEN = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } sram_state_t;

    // Offset into data memory; wraps modulo 2^ADDRESS_LEN.
    function automatic logic [ADDRESS_LEN-1:0] mem_offset(
        input logic [ADDRESS_LEN-1:0] addr,
        input logic [ADDRESS_LEN-1:0] base
    );
        return addr - base;
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Per-halfword hold counter: counts cycles on the SRAM pins and
// flags the last cycle of each half-word access.
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 1,
    localparam int CW = $clog2(WAIT_CYCLES) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// Splits a 32-bit memory-stage access into two 16-bit SRAM accesses
// and holds the pipeline (ready=0) until both halves are done.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int WAIT_CYCLES   = 1,
    parameter int BASE_ADDR     = 1024,
    parameter int SRAM_ADDR_LEN = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic                     wr_en,
    input  logic [ADDRESS_LEN-1:0]   address,
    input  logic [DATA_LEN-1:0]      write_data,
    output logic [DATA_LEN-1:0]      read_data,
    output logic                     ready,
    output logic [SRAM_ADDR_LEN-1:0] sram_addr,
    output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
    output logic                     sram_dq_oe,
    input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
    output logic                     sram_we_n
);

    localparam int BW = SRAM_ADDR_LEN - 1;
    localparam int HW = SRAM_DATA_LEN;

    sram_state_t r_state;
    sram_state_t w_next_state;

    logic                     r_is_wr;
    logic [BW-1:0]            r_base;
    logic [DATA_LEN-1:0]      r_wdata;
    logic [DATA_LEN-1:0]      r_read_data;
    logic [SRAM_ADDR_LEN-1:0] r_sram_addr;
    logic [HW-1:0]            r_dq_out;
    logic                     r_dq_oe;
    logic                     r_we_n;

    logic                     w_req;
    logic                     w_busy;
    logic                     w_tc;
    logic                     w_tc_hit;
    logic                     w_cnt_clear;
    logic                     w_cap_lo;
    logic                     w_cap_hi;
    logic                     w_ready;
    logic [ADDRESS_LEN-1:0]   w_off;
    logic [BW-1:0]            w_req_base;
    logic                     w_unused_off;
    logic                     w_src_wr;
    logic [BW-1:0]            w_src_base;
    logic [DATA_LEN-1:0]      w_src_data;
    logic [SRAM_ADDR_LEN-1:0] w_nxt_addr;
    logic [HW-1:0]            w_nxt_dq;
    logic                     w_nxt_oe;
    logic                     w_nxt_we_n;

    assign w_req        = rd_en | wr_en;
    assign w_off        = mem_offset(address, ADDRESS_LEN'(BASE_ADDR));
    assign w_req_base   = w_off[SRAM_ADDR_LEN:2];
    assign w_unused_off = ^{w_off[ADDRESS_LEN-1:SRAM_ADDR_LEN+1], w_off[1:0]};
    assign w_busy       = (r_state == ST_LO) || (r_state == ST_HI);
    assign w_tc_hit     = w_busy && w_tc;
    assign w_cnt_clear  = w_tc_hit || !w_busy;

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait (
        .clk    (clk),
        .rst    (rst),
        .i_clear(w_cnt_clear),
        .i_en   (w_busy),
        .o_tc   (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: if (w_req) w_next_state = ST_LO;
            ST_LO:   if (w_tc) w_next_state = ST_HI;
            ST_HI:   if (w_tc) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Pin values are decoded for the upcoming state and then registered,
    // so the strobe, address and data all switch on the same clock edge.
    always_comb begin
        w_src_wr   = (r_state == ST_IDLE) ? wr_en : r_is_wr;
        w_src_base = (r_state == ST_IDLE) ? w_req_base : r_base;
        w_src_data = (r_state == ST_IDLE) ? write_data : r_wdata;
        w_nxt_addr = r_sram_addr;
        w_nxt_dq   = r_dq_out;
        w_nxt_oe   = 1'b0;
        w_nxt_we_n = 1'b1;
        unique case (w_next_state)
            ST_LO: begin
                w_nxt_addr = {w_src_base, 1'b0};
                if (w_src_wr) begin
                    w_nxt_dq   = w_src_data[HW-1:0];
                    w_nxt_oe   = 1'b1;
                    w_nxt_we_n = 1'b0;
                end
            end
            ST_HI: begin
                w_nxt_addr = {w_src_base, 1'b1};
                if (w_src_wr) begin
                    w_nxt_dq   = w_src_data[DATA_LEN-1:HW];
                    w_nxt_oe   = 1'b1;
                    w_nxt_we_n = 1'b0;
                end
            end
            default: ;
        endcase
        w_cap_lo = (r_state == ST_LO) && w_tc && !r_is_wr;
        w_cap_hi = (r_state == ST_HI) && w_tc && !r_is_wr;
        w_ready  = 1'b0;
        unique case (r_state)
            ST_IDLE: w_ready = !w_req;
            ST_DONE: w_ready = 1'b1;
            default: w_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_is_wr     <= 1'b0;
            r_base      <= '0;
            r_wdata     <= '0;
            r_read_data <= '0;
            r_sram_addr <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
        end else begin
            if ((r_state == ST_IDLE) && w_req) begin
                r_is_wr <= wr_en;
                r_base  <= w_req_base;
                r_wdata <= write_data;
            end
            if (w_cap_lo) begin
                r_read_data[HW-1:0] <= sram_dq_in;
            end
            if (w_cap_hi) begin
                r_read_data[DATA_LEN-1:HW] <= sram_dq_in;
            end
            r_sram_addr <= w_nxt_addr;
            r_dq_out    <= w_nxt_dq;
            r_dq_oe     <= w_nxt_oe;
            r_we_n      <= w_nxt_we_n;
        end
    end

    assign read_data   = r_read_data;
    assign ready       = w_ready;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_dq_oe;
    assign sram_we_n   = r_we_n;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench: random word accesses against a halfword-array model,
// plus directed reset-abort and long-wait checks.
module tb_sram_controller;

    localparam int AL   = 18;
    localparam int BASE = 1024;
    localparam int W1   = 1;
    localparam int W3   = 3;
    localparam int MSZ  = 1 << AL;

    typedef struct {
        bit          is_wr;
        logic [17:0] lo;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          issue;
    } item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic        rst, rd_en, wr_en, ready, dq_oe, we_n;
    logic [31:0] address, write_data, read_data;
    logic [17:0] sram_addr;
    logic [15:0] dq_out, dq_in;

    logic        t_rst, t_rd, t_wr, t_ready, t_oe, t_we_n;
    logic [31:0] t_address, t_wd, t_rdata;
    logic [17:0] t_saddr;
    logic [15:0] t_dq_out, t_dq_in;

    bit [15:0] mem1 [0:MSZ-1];
    bit [15:0] mem3 [0:MSZ-1];
    bit [15:0] ref_mem [0:MSZ-1];

    item_t       q[$];
    logic [17:0] touched[$];
    logic [31:0] last_rd;

    sram_controller #(
        .WAIT_CYCLES(W1), .BASE_ADDR(BASE), .SRAM_ADDR_LEN(AL)
    ) u_dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .write_data(write_data),
        .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(dq_out),
        .sram_dq_oe(dq_oe), .sram_dq_in(dq_in), .sram_we_n(we_n)
    );

    sram_controller #(
        .WAIT_CYCLES(W3), .BASE_ADDR(BASE), .SRAM_ADDR_LEN(AL)
    ) u_dut3 (
        .clk(clk), .rst(t_rst), .rd_en(t_rd), .wr_en(t_wr),
        .address(t_address), .write_data(t_wd),
        .read_data(t_rdata), .ready(t_ready),
        .sram_addr(t_saddr), .sram_dq_out(t_dq_out),
        .sram_dq_oe(t_oe), .sram_dq_in(t_dq_in), .sram_we_n(t_we_n)
    );

    // Asynchronous SRAM models: read is combinational, write lands while we_n is low.
    assign dq_in   = mem1[sram_addr];
    assign t_dq_in = mem3[t_saddr];
    always @(posedge clk) if (we_n === 1'b0) mem1[sram_addr] <= dq_out;
    always @(posedge clk) if (t_we_n === 1'b0) mem3[t_saddr] <= t_dq_out;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] lo_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'(BASE);
        return 18'(((off >> 2) % (1 << (AL - 1))) * 2);
    endfunction

    // Monitor: walks the front scoreboard entry through its expected timeline.
    item_t m_it;
    int    m_k;
    bit    m_hi;
    always @(negedge clk) begin
        if (rst === 1'b1 && q.size() > 0) begin
            m_it = q[0];
            m_k  = cyc - m_it.issue;
            if (m_k == 0) begin
                chk("req_ready", {31'd0, ready}, 32'd0);
            end else if (m_k <= 2 * W1) begin
                m_hi = (m_k > W1);
                chk("busy_ready", {31'd0, ready}, 32'd0);
                chk("sram_addr", {14'd0, sram_addr},
                    {14'd0, m_it.lo + (m_hi ? 18'd1 : 18'd0)});
                chk("we_n", {31'd0, we_n}, {31'd0, !m_it.is_wr});
                chk("dq_oe", {31'd0, dq_oe}, {31'd0, m_it.is_wr});
                if (m_it.is_wr)
                    chk("dq_out", {16'd0, dq_out},
                        {16'd0, m_hi ? m_it.wdata[31:16] : m_it.wdata[15:0]});
            end else begin
                chk("done_ready", {31'd0, ready}, 32'd1);
                chk("read_data", read_data, m_it.exp_rd);
                chk("done_we_n", {31'd0, we_n}, 32'd1);
                chk("done_oe", {31'd0, dq_oe}, 32'd0);
                void'(q.pop_front());
            end
        end
    end

    // Entered just after a rising edge; leaves just after the edge following ready.
    task automatic do_req(input bit w, input bit r, input logic [31:0] a,
                          input logic [31:0] d);
        item_t it;
        bit    got;
        it.is_wr = w;
        it.lo    = lo_of(a);
        it.wdata = d;
        it.issue = cyc;
        if (w) begin
            ref_mem[it.lo]     = d[15:0];
            ref_mem[it.lo + 1] = d[31:16];
            it.exp_rd          = last_rd;
        end else begin
            it.exp_rd = {ref_mem[it.lo + 1], ref_mem[it.lo]};
            last_rd   = it.exp_rd;
        end
        touched.push_back(it.lo);
        q.push_back(it);
        wr_en      = w;
        rd_en      = r;
        address    = a;
        write_data = d;
        got        = 1'b0;
        for (int i = 0; i < 4 * W1 + 8; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: got no ready expected ready by %0d cycles",
                     2 * W1 + 1);
            q.delete();
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic w3_access(input bit w, input logic [31:0] a,
                             input logic [31:0] d, output int lat,
                             output int wl);
        t_wr      = w;
        t_rd      = !w;
        t_address = a;
        t_wd      = d;
        wl        = 0;
        lat       = 0;
        for (lat = 0; lat < 30; lat++) begin
            @(negedge clk);
            if (t_ready === 1'b1) break;
            if (lat > 0) begin
                chk("w3_addr", {14'd0, t_saddr},
                    {14'd0, lo_of(a) + ((lat > W3) ? 18'd1 : 18'd0)});
            end
            if (t_we_n === 1'b0) begin
                wl++;
                chk("w3_oe", {31'd0, t_oe}, 32'd1);
            end
        end
        @(posedge clk);
        #1;
        t_wr = 1'b0;
        t_rd = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          wl;
        bit          w;
        bit          r;
        logic [31:0] a;
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        address = '0; write_data = '0;
        t_rst = 1'b0; t_rd = 1'b0; t_wr = 1'b0;
        t_address = '0; t_wd = '0;
        last_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b1;
        t_rst = 1'b1;

        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_we_n", {31'd0, we_n}, 32'd1);
        chk("rst_oe", {31'd0, dq_oe}, 32'd0);
        chk("rst_addr", {14'd0, sram_addr}, 32'd0);
        chk("rst_dq", {16'd0, dq_out}, 32'd0);
        chk("rst_rdata", read_data, 32'd0);

        do_req(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
        chk("mem0", {16'd0, mem1[0]}, 32'h0000BEEF);
        chk("mem1", {16'd0, mem1[1]}, 32'h0000DEAD);
        do_req(1'b0, 1'b1, 32'd1024, 32'h0);
        do_req(1'b1, 1'b1, 32'd1028, 32'h12345678);
        chk("mem2", {16'd0, mem1[2]}, 32'h00005678);
        chk("mem3", {16'd0, mem1[3]}, 32'h00001234);

        // Abort a write after its low half: high half must stay untouched.
        do_req(1'b1, 1'b0, 32'd1040, 32'h11112222);
        wr_en = 1'b1; address = 32'd1040; write_data = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        chk("abort_lo_we_n", {31'd0, we_n}, 32'd0);
        chk("abort_lo_addr", {14'd0, sram_addr}, 32'd8);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_we_n", {31'd0, we_n}, 32'd1);
        chk("abort_oe", {31'd0, dq_oe}, 32'd0);
        chk("abort_addr", {14'd0, sram_addr}, 32'd0);
        chk("abort_rdata", read_data, 32'd0);
        chk("abort_ready_req", {31'd0, ready}, 32'd0);
        wr_en = 1'b0;
        #1;
        chk("abort_ready_idle", {31'd0, ready}, 32'd1);
        ref_mem[8] = 16'hF00D;
        last_rd    = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("abort_hi_kept", {16'd0, mem1[9]}, 32'h00001111);
        do_req(1'b0, 1'b1, 32'd1040, 32'h0);

        // Back-to-back: three requests with no idle cycle between them.
        do_req(1'b1, 1'b0, 32'd1048, 32'hA1B2C3D4);
        do_req(1'b1, 1'b0, 32'd1052, 32'h0F1E2D3C);
        do_req(1'b0, 1'b1, 32'd1048, 32'h0);

        for (int n = 0; n < 60; n++) begin
            w = 1'($urandom_range(0, 1));
            r = w ? 1'($urandom_range(0, 1)) : 1'b1;
            if ($urandom_range(0, 9) < 7)
                a = 32'(BASE + 4 * $urandom_range(0, 31));
            else
                a = 32'(4 * $urandom_range(0, 7));
            a = a | 32'($urandom_range(0, 3));
            do_req(w, r, a, $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        foreach (touched[i]) begin
            chk("sweep_lo", {16'd0, mem1[touched[i]]},
                {16'd0, ref_mem[touched[i]]});
            chk("sweep_hi", {16'd0, mem1[touched[i] + 1]},
                {16'd0, ref_mem[touched[i] + 1]});
        end

        w3_access(1'b1, 32'd1036, 32'hA5A55A5A, lat, wl);
        chk("w3_wr_latency", lat, 32'd7);
        chk("w3_we_low", wl, 32'd6);
        chk("w3_mem6", {16'd0, mem3[6]}, 32'h00005A5A);
        chk("w3_mem7", {16'd0, mem3[7]}, 32'h0000A5A5);
        chk("w3_rdata_wr", t_rdata, 32'd0);
        w3_access(1'b0, 32'd1036, 32'h0, lat, wl);
        chk("w3_rd_latency", lat, 32'd7);
        chk("w3_rd_we_low", wl, 32'd0);
        chk("w3_rdata", t_rdata, 32'hA5A55A5A);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
